// File: rtl/core_pkg.sv
// Shared RV32I decode types: op classes, immediate formats, opcodes and the ID/EX payload.
package core_pkg;

    localparam int unsigned XLEN = 32;

    typedef enum logic [3:0] {
        OP_NOP     = 4'd0,
        OP_LUI     = 4'd1,
        OP_AUIPC   = 4'd2,
        OP_JAL     = 4'd3,
        OP_JALR    = 4'd4,
        OP_BRANCH  = 4'd5,
        OP_LOAD    = 4'd6,
        OP_STORE   = 4'd7,
        OP_OPIMM   = 4'd8,
        OP_OP      = 4'd9,
        OP_FENCE   = 4'd10,
        OP_SYSTEM  = 4'd11,
        OP_ILLEGAL = 4'd12
    } op_e;

    typedef enum logic [2:0] {
        IMM_NONE = 3'd0,
        IMM_I    = 3'd1,
        IMM_S    = 3'd2,
        IMM_B    = 3'd3,
        IMM_U    = 3'd4,
        IMM_J    = 3'd5
    } imm_sel_e;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        logic [XLEN-1:0] imm;
        logic [4:0]      rd;
        logic            rd_we;
        op_e             op;
        logic [2:0]      funct3;
        logic            funct7b5;
        logic            illegal;
    } idex_t;

endpackage

// File: rtl/id_stage_if.sv
// Signal bundle around the decode stage: fetch, regfile read ports, writeback, flush and ID/EX.
interface id_stage_if
    import core_pkg::*;
#(
    parameter int unsigned XLEN = 32
) ();

    logic            if_valid_i;
    logic            if_ready_o;
    logic [XLEN-1:0] if_pc_i;
    logic [31:0]     if_instr_i;
    logic            rf_rw1_o;
    logic [4:0]      rf_addr1_o;
    logic [XLEN-1:0] rf_data1_i;
    logic            rf_rw2_o;
    logic [4:0]      rf_addr2_o;
    logic [XLEN-1:0] rf_data2_i;
    logic            wb_we_i;
    logic [4:0]      wb_rd_i;
    logic [XLEN-1:0] wb_data_i;
    logic            flush_i;
    logic            ex_valid_o;
    logic            ex_ready_i;
    logic [XLEN-1:0] ex_pc_o;
    logic [4:0]      ex_rs1_o;
    logic [4:0]      ex_rs2_o;
    logic [XLEN-1:0] ex_rs1_data_o;
    logic [XLEN-1:0] ex_rs2_data_o;
    logic [XLEN-1:0] ex_imm_o;
    logic [4:0]      ex_rd_o;
    logic            ex_rd_we_o;
    op_e             ex_op_o;
    logic [2:0]      ex_funct3_o;
    logic            ex_funct7b5_o;
    logic            ex_illegal_o;

    modport slave (
        input  if_valid_i, if_pc_i, if_instr_i, rf_data1_i, rf_data2_i,
               wb_we_i, wb_rd_i, wb_data_i, flush_i, ex_ready_i,
        output if_ready_o, rf_rw1_o, rf_addr1_o, rf_rw2_o, rf_addr2_o,
               ex_valid_o, ex_pc_o, ex_rs1_o, ex_rs2_o, ex_rs1_data_o, ex_rs2_data_o,
               ex_imm_o, ex_rd_o, ex_rd_we_o, ex_op_o, ex_funct3_o, ex_funct7b5_o, ex_illegal_o
    );

    modport master (
        output if_valid_i, if_pc_i, if_instr_i, rf_data1_i, rf_data2_i,
               wb_we_i, wb_rd_i, wb_data_i, flush_i, ex_ready_i,
        input  if_ready_o, rf_rw1_o, rf_addr1_o, rf_rw2_o, rf_addr2_o,
               ex_valid_o, ex_pc_o, ex_rs1_o, ex_rs2_o, ex_rs1_data_o, ex_rs2_data_o,
               ex_imm_o, ex_rd_o, ex_rd_we_o, ex_op_o, ex_funct3_o, ex_funct7b5_o, ex_illegal_o
    );

endinterface

// File: rtl/id_stage_imm_gen.sv
// Combinational RV32I immediate builder; opcode bits are not needed, so only instr[31:7] enters.
module imm_gen
    import core_pkg::*;
(
    input  logic [31:7] instr_i,
    input  imm_sel_e    sel_i,
    output logic [31:0] imm_o
);

    always_comb begin
        imm_o = '0;
        unique case (sel_i)
            IMM_I:   imm_o = {{20{instr_i[31]}}, instr_i[31:20]};
            IMM_S:   imm_o = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
            IMM_B:   imm_o = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25],
                              instr_i[11:8], 1'b0};
            IMM_U:   imm_o = {instr_i[31:12], 12'b0};
            IMM_J:   imm_o = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20],
                              instr_i[30:21], 1'b0};
            default: imm_o = '0;
        endcase
    end

endmodule

// File: rtl/id_stage.sv
// RV32I decode/operand-read stage: decoder, x0/writeback bypass and the ID/EX register.
module id_stage
    import core_pkg::*;
#(
    parameter int unsigned XLEN      = 32,
    parameter bit          BYPASS_EN = 1'b1
) (
    input logic clk_i,
    input logic rst_i,
    id_stage_if.slave bus
);

    logic [31:0]     instr;
    logic [4:0]      rs1, rs2, rd;
    logic [XLEN-1:0] op1, op2, imm;
    op_e             op;
    imm_sel_e        imm_sel;
    logic            writes_rd;
    logic            accept, hold;
    logic            ex_valid_d, ex_valid_q;
    idex_t           pay_d, pay_q;

    assign instr = bus.if_instr_i;
    assign rs1   = instr[19:15];
    assign rs2   = instr[24:20];
    assign rd    = instr[11:7];

    assign bus.rf_rw1_o   = 1'b0;
    assign bus.rf_rw2_o   = 1'b0;
    assign bus.rf_addr1_o = rs1;
    assign bus.rf_addr2_o = rs2;

    always_comb begin
        op        = OP_ILLEGAL;
        imm_sel   = IMM_NONE;
        writes_rd = 1'b0;
        unique case (instr[6:0])
            OPC_LUI:    begin op = OP_LUI;    imm_sel = IMM_U; writes_rd = 1'b1; end
            OPC_AUIPC:  begin op = OP_AUIPC;  imm_sel = IMM_U; writes_rd = 1'b1; end
            OPC_JAL:    begin op = OP_JAL;    imm_sel = IMM_J; writes_rd = 1'b1; end
            OPC_JALR:   begin op = OP_JALR;   imm_sel = IMM_I; writes_rd = 1'b1; end
            OPC_BRANCH: begin op = OP_BRANCH; imm_sel = IMM_B; end
            OPC_LOAD:   begin op = OP_LOAD;   imm_sel = IMM_I; writes_rd = 1'b1; end
            OPC_STORE:  begin op = OP_STORE;  imm_sel = IMM_S; end
            OPC_OPIMM:  begin op = OP_OPIMM;  imm_sel = IMM_I; writes_rd = 1'b1; end
            OPC_OP:     begin op = OP_OP;     writes_rd = 1'b1; end
            OPC_FENCE:  begin op = OP_FENCE; end
            OPC_SYSTEM: begin op = OP_SYSTEM; imm_sel = IMM_I; end
            default:    begin op = OP_ILLEGAL; end
        endcase
    end

    imm_gen u_imm_gen (
        .instr_i (instr[31:7]),
        .sel_i   (imm_sel),
        .imm_o   (imm)
    );

    // x0 beats forwarding, forwarding beats the regfile read
    always_comb begin
        op1 = bus.rf_data1_i;
        op2 = bus.rf_data2_i;
        if (rs1 == 5'd0) begin
            op1 = '0;
        end else if (BYPASS_EN && bus.wb_we_i && bus.wb_rd_i == rs1) begin
            op1 = bus.wb_data_i;
        end
        if (rs2 == 5'd0) begin
            op2 = '0;
        end else if (BYPASS_EN && bus.wb_we_i && bus.wb_rd_i == rs2) begin
            op2 = bus.wb_data_i;
        end
    end

    assign bus.if_ready_o = ~ex_valid_q | bus.ex_ready_i | bus.flush_i;
    assign accept         = bus.if_valid_i & bus.if_ready_o;
    assign hold           = ex_valid_q & ~bus.ex_ready_i & ~bus.flush_i;

    always_comb begin
        ex_valid_d = ex_valid_q;
        pay_d      = pay_q;
        if (bus.flush_i) begin
            ex_valid_d = 1'b0;
        end else if (accept) begin
            ex_valid_d = 1'b1;
        end else if (bus.ex_ready_i) begin
            ex_valid_d = 1'b0;
        end

        if (accept && !bus.flush_i) begin
            pay_d.pc       = bus.if_pc_i;
            pay_d.rs1      = rs1;
            pay_d.rs2      = rs2;
            pay_d.rs1_data = op1;
            pay_d.rs2_data = op2;
            pay_d.imm      = imm;
            pay_d.rd       = rd;
            pay_d.rd_we    = writes_rd & (rd != 5'd0);
            pay_d.op       = op;
            pay_d.funct3   = instr[14:12];
            pay_d.funct7b5 = instr[30];
            pay_d.illegal  = (op == OP_ILLEGAL);
        end else if (hold && BYPASS_EN && bus.wb_we_i && bus.wb_rd_i != 5'd0) begin
            // a stalled instruction must still see writebacks that land while it waits
            if (bus.wb_rd_i == pay_q.rs1) pay_d.rs1_data = bus.wb_data_i;
            if (bus.wb_rd_i == pay_q.rs2) pay_d.rs2_data = bus.wb_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ex_valid_q <= 1'b0;
            pay_q      <= '0;
            pay_q.op   <= OP_NOP;
        end else begin
            ex_valid_q <= ex_valid_d;
            pay_q      <= pay_d;
        end
    end

    assign bus.ex_valid_o    = ex_valid_q;
    assign bus.ex_pc_o       = pay_q.pc;
    assign bus.ex_rs1_o      = pay_q.rs1;
    assign bus.ex_rs2_o      = pay_q.rs2;
    assign bus.ex_rs1_data_o = pay_q.rs1_data;
    assign bus.ex_rs2_data_o = pay_q.rs2_data;
    assign bus.ex_imm_o      = pay_q.imm;
    assign bus.ex_rd_o       = pay_q.rd;
    assign bus.ex_rd_we_o    = pay_q.rd_we;
    assign bus.ex_op_o       = pay_q.op;
    assign bus.ex_funct3_o   = pay_q.funct3;
    assign bus.ex_funct7b5_o = pay_q.funct7b5;
    assign bus.ex_illegal_o  = pay_q.illegal;

endmodule

// File: tb/tb_id_stage.sv
// Directed-vector bench for id_stage with hand-computed expectations.
module tb_id_stage;
    import core_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int unsigned n_chk  = 0;
    int unsigned n_fail = 0;

    always #5 clk = ~clk;

    id_stage_if #(.XLEN(32)) bus ();

    id_stage #(.XLEN(32), .BYPASS_EN(1'b1)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [31:0] pc, input logic [31:0] instr);
        bus.if_valid_i = 1'b1;
        bus.if_pc_i    = pc;
        bus.if_instr_i = instr;
    endtask

    initial begin
        bus.if_valid_i = 1'b0;
        bus.if_pc_i    = '0;
        bus.if_instr_i = '0;
        bus.rf_data1_i = '0;
        bus.rf_data2_i = '0;
        bus.wb_we_i    = 1'b0;
        bus.wb_rd_i    = '0;
        bus.wb_data_i  = '0;
        bus.flush_i    = 1'b0;
        bus.ex_ready_i = 1'b1;

        repeat (3) step();
        rst = 1'b0;
        #1;
        check("rst_valid", 32'(bus.ex_valid_o), 32'd0);
        check("rst_ready", 32'(bus.if_ready_o), 32'd1);
        check("rst_op",    32'(bus.ex_op_o),    32'(OP_NOP));
        check("rst_rdwe",  32'(bus.ex_rd_we_o), 32'd0);

        // addi x5,x0,-1 : rs1 is x0, so regfile garbage must be masked
        present(32'h100, 32'hFFF00293);
        bus.rf_data1_i = 32'hDEAD_BEEF;
        step();
        bus.if_valid_i = 1'b0;
        check("addi_valid", 32'(bus.ex_valid_o),  32'd1);
        check("addi_imm",   bus.ex_imm_o,         32'hFFFF_FFFF);
        check("addi_rs1d",  bus.ex_rs1_data_o,    32'd0);
        check("addi_rd",    32'(bus.ex_rd_o),     32'd5);
        check("addi_rdwe",  32'(bus.ex_rd_we_o),  32'd1);
        check("addi_op",    32'(bus.ex_op_o),     32'(OP_OPIMM));
        check("addi_pc",    bus.ex_pc_o,          32'h100);

        // add x3,x1,x2 with writeback of x1 in the same cycle
        present(32'h104, 32'h002081B3);
        bus.rf_data1_i = 32'd0;
        bus.rf_data2_i = 32'h22;
        bus.wb_we_i    = 1'b1;
        bus.wb_rd_i    = 5'd1;
        bus.wb_data_i  = 32'hA5A5_A5A5;
        #1;
        check("add_addr1", 32'(bus.rf_addr1_o), 32'd1);
        check("add_addr2", 32'(bus.rf_addr2_o), 32'd2);
        step();
        check("add_rs1d", bus.ex_rs1_data_o, 32'hA5A5_A5A5);
        check("add_rs2d", bus.ex_rs2_data_o, 32'h22);
        check("add_op",   32'(bus.ex_op_o),  32'(OP_OP));
        check("add_rd",   32'(bus.ex_rd_o),  32'd3);

        // three stall cycles, writeback of x2 in the second
        present(32'h108, 32'h00100393);
        bus.ex_ready_i = 1'b0;
        bus.wb_we_i    = 1'b0;
        #1;
        check("hold1_ready", 32'(bus.if_ready_o), 32'd0);
        step();
        check("hold1_rs2d", bus.ex_rs2_data_o, 32'h22);
        check("hold1_pc",   bus.ex_pc_o,       32'h104);
        bus.wb_we_i   = 1'b1;
        bus.wb_rd_i   = 5'd2;
        bus.wb_data_i = 32'h1234;
        #1;
        check("hold2_ready", 32'(bus.if_ready_o), 32'd0);
        step();
        bus.wb_we_i = 1'b0;
        #1;
        check("hold3_ready", 32'(bus.if_ready_o),   32'd0);
        check("hold2_rs2d",  bus.ex_rs2_data_o,     32'h1234);
        check("hold2_rs1d",  bus.ex_rs1_data_o,     32'hA5A5_A5A5);
        check("hold2_rd",    32'(bus.ex_rd_o),      32'd3);
        check("hold2_valid", 32'(bus.ex_valid_o),   32'd1);
        step();
        check("hold3_rs2d", bus.ex_rs2_data_o, 32'h1234);
        check("hold3_pc",   bus.ex_pc_o,       32'h104);
        check("hold3_op",   32'(bus.ex_op_o),  32'(OP_OP));

        // flush with a new instruction presented: both die
        present(32'h200, 32'h00100393);
        bus.flush_i = 1'b1;
        #1;
        check("flush_ready", 32'(bus.if_ready_o), 32'd1);
        step();
        bus.flush_i    = 1'b0;
        bus.if_valid_i = 1'b0;
        check("flush_valid", 32'(bus.ex_valid_o), 32'd0);
        step();
        check("flush_valid2", 32'(bus.ex_valid_o), 32'd0);

        // unknown opcode 0x7F with rd=x1
        bus.ex_ready_i = 1'b1;
        present(32'h300, 32'h0000_00FF);
        step();
        check("ill_valid", 32'(bus.ex_valid_o),   32'd1);
        check("ill_flag",  32'(bus.ex_illegal_o), 32'd1);
        check("ill_rdwe",  32'(bus.ex_rd_we_o),   32'd0);
        check("ill_op",    32'(bus.ex_op_o),      32'(OP_ILLEGAL));

        // beq x1,x2,-4
        present(32'h304, 32'hFE20_8EE3);
        step();
        check("beq_imm",  bus.ex_imm_o,         32'hFFFF_FFFC);
        check("beq_rdwe", 32'(bus.ex_rd_we_o),  32'd0);
        check("beq_op",   32'(bus.ex_op_o),     32'(OP_BRANCH));
        check("beq_ill",  32'(bus.ex_illegal_o), 32'd0);

        // lui x10,0x12345
        present(32'h308, 32'h1234_5537);
        step();
        check("lui_imm",  bus.ex_imm_o,        32'h1234_5000);
        check("lui_rdwe", 32'(bus.ex_rd_we_o), 32'd1);
        check("lui_pc",   bus.ex_pc_o,         32'h308);

        // reset while holding drops the instruction
        bus.if_valid_i = 1'b0;
        bus.ex_ready_i = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        check("rhold_valid", 32'(bus.ex_valid_o), 32'd0);
        check("rhold_ready", 32'(bus.if_ready_o), 32'd1);
        check("rhold_op",    32'(bus.ex_op_o),    32'(OP_NOP));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
